// File: rtl/caravel_wb_port_pkg.sv
// Shared constants for the Caravel user-area Wishbone slave: register
// offsets (word index taken from wbs_adr_i[4:2]), CTRL bit positions and
// the default parameter values used by the top level.
package caravel_wb_port_pkg;

  localparam logic [2:0] ADDR_COUNT   = 3'd0;
  localparam logic [2:0] ADDR_CTRL    = 3'd1;
  localparam logic [2:0] ADDR_IO_DATA = 3'd2;
  localparam logic [2:0] ADDR_IO_OEB  = 3'd3;
  localparam logic [2:0] ADDR_COMPARE = 3'd4;
  localparam logic [2:0] ADDR_STATUS  = 3'd5;

  localparam int CTRL_EN_BIT = 0;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
  localparam logic [31:0] DEF_RESET_OEB = 32'hFFFF_FFFF;

  // True when the upper half of a byte address falls in the slave window.
  function automatic logic addr_hit(input logic [31:0] adr, input logic [31:0] base);
    return adr[31:16] == base[31:16];
  endfunction

endpackage

// File: rtl/caravel_wb_port_if.sv
// Wishbone-classic bus bundle between the management SoC (master) and the
// user-project slave. Signal names keep the Caravel wbs_* spelling.
//
// Handshake: a transfer is requested while cyc and stb are both high and
// the address hits the slave window. The slave answers with a one-cycle
// ack pulse; the write commits and read data is captured on the edge that
// raises ack. Dropping cyc or stb before ack abandons the transfer.
interface caravel_wb_port_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/caravel_wb_port_wb_byte_reg.sv
// 32-bit register with one write enable per byte lane and a parameterised
// reset value. Lanes whose enable is low keep their previous contents.
module wb_byte_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic [3:0]  be,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  // Merge the enabled byte lanes of d over the held value.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) q_d[8*i +: 8] = d[8*i +: 8];
    end
  end

  // State register, cleared asynchronously to RESET_VAL.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) q_q <= RESET_VAL;
    else         q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/caravel_wb_port.sv
// Caravel user-area Wishbone slave: free-running counter, control register
// and GPIO data / output-enable registers driving mprj_io[31:0].
// Optional compare/interrupt logic is compiled in with the macro
// CARAVEL_WB_PORT_IRQ_EN (COMPARE at 0x10, sticky W1C STATUS at 0x14).
module caravel_wb_port
  import caravel_wb_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] RESET_OEB = DEF_RESET_OEB
) (
  input  logic               clock,
  input  logic               resetb,
  caravel_wb_port_if.slave   wb,
  output logic [31:0]        io_out,
  output logic [31:0]        io_oeb,
  output logic               irq_o
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        en_q, en_d;

  logic        sel;
  logic        access;
  logic        wr;
  logic        rd;
  logic [2:0]  offset;

  logic [31:0] count_q;
  logic [3:0]  count_be;
  logic [31:0] count_wd;
  logic [3:0]  io_data_be;
  logic [3:0]  io_oeb_be;
  logic [31:0] rd_mux;

  // Address bits below the word index and inside the 64 KiB window are
  // not decoded; the block aliases every 32 bytes.
  logic unused_adr;
  assign unused_adr = ^{wb.wbs_adr_i[15:5], wb.wbs_adr_i[1:0]};

  assign sel    = wb.wbs_cyc_i & wb.wbs_stb_i & addr_hit(wb.wbs_adr_i, BASE_ADDR);
  // A new access starts only while ack is low, giving the 2-cycle cadence.
  assign access = sel & ~ack_q;
  assign wr     = access & wb.wbs_we_i;
  assign rd     = access & ~wb.wbs_we_i;
  assign offset = wb.wbs_adr_i[4:2];

  // Counter lanes: a committing write owns the selected lanes and freezes
  // the rest; otherwise all lanes take count+1 while enabled.
  always_comb begin
    count_be = 4'h0;
    count_wd = count_q + 32'd1;
    if (wr && offset == ADDR_COUNT) begin
      count_be = wb.wbs_sel_i;
      count_wd = wb.wbs_dat_i;
    end else if (en_q) begin
      count_be = 4'hF;
    end
  end

  // Byte-lane enables for the plain GPIO registers.
  always_comb begin
    io_data_be = 4'h0;
    io_oeb_be  = 4'h0;
    if (wr && offset == ADDR_IO_DATA) io_data_be = wb.wbs_sel_i;
    if (wr && offset == ADDR_IO_OEB)  io_oeb_be  = wb.wbs_sel_i;
  end

  wb_byte_reg #(.RESET_VAL(32'h0)) u_count (
    .clock (clock), .resetb (resetb),
    .be    (count_be), .d (count_wd), .q (count_q)
  );

  wb_byte_reg #(.RESET_VAL(32'h0)) u_io_data (
    .clock (clock), .resetb (resetb),
    .be    (io_data_be), .d (wb.wbs_dat_i), .q (io_out)
  );

  wb_byte_reg #(.RESET_VAL(RESET_OEB)) u_io_oeb (
    .clock (clock), .resetb (resetb),
    .be    (io_oeb_be), .d (wb.wbs_dat_i), .q (io_oeb)
  );

`ifdef CARAVEL_WB_PORT_IRQ_EN
  logic [31:0] compare_q;
  logic [3:0]  compare_be;
  logic        match_q, match_d;
  logic        match_set;
  logic        match_clr;

  assign compare_be = (wr && offset == ADDR_COMPARE) ? wb.wbs_sel_i : 4'h0;

  wb_byte_reg #(.RESET_VAL(32'h0)) u_compare (
    .clock (clock), .resetb (resetb),
    .be    (compare_be), .d (wb.wbs_dat_i), .q (compare_q)
  );

  // Sticky match flag; a set in the same cycle as a W1C wins.
  always_comb begin
    match_set = en_q & (count_q == compare_q);
    match_clr = wr & (offset == ADDR_STATUS) & wb.wbs_sel_i[0] & wb.wbs_dat_i[0];
    match_d   = match_set | (match_q & ~match_clr);
  end

  // Match flag register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) match_q <= 1'b0;
    else         match_q <= match_d;
  end

  assign irq_o = match_q;
`else
  assign irq_o = 1'b0;
`endif

  // Read mux; unused and reserved offsets return zero.
  always_comb begin
    rd_mux = 32'h0;
    case (offset)
      ADDR_COUNT:   rd_mux = count_q;
      ADDR_CTRL:    rd_mux[CTRL_EN_BIT] = en_q;
      ADDR_IO_DATA: rd_mux = io_out;
      ADDR_IO_OEB:  rd_mux = io_oeb;
`ifdef CARAVEL_WB_PORT_IRQ_EN
      ADDR_COMPARE: rd_mux = compare_q;
      ADDR_STATUS:  rd_mux[0] = match_q;
`endif
      default:      rd_mux = 32'h0;
    endcase
  end

  // Next-state for ack, read data and the CTRL enable bit.
  always_comb begin
    ack_d = access;
    dat_d = dat_q;
    en_d  = en_q;
    if (rd) dat_d = rd_mux;
    if (wr && offset == ADDR_CTRL && wb.wbs_sel_i[0]) en_d = wb.wbs_dat_i[CTRL_EN_BIT];
  end

  // Bus-side and control state registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ack_q <= 1'b0;
      dat_q <= 32'h0;
      en_q  <= 1'b0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      en_q  <= en_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;

endmodule

// File: tb/tb_caravel_wb_port.sv
// Self-checking bench for caravel_wb_port: register access, byte lanes,
// counter wrap, address decode, back-to-back ack cadence, reset during a
// pending access and, with CARAVEL_WB_PORT_IRQ_EN, the compare interrupt.
module tb_caravel_wb_port;

  logic        clock;
  logic        resetb;
  logic [31:0] io_out;
  logic [31:0] io_oeb;
  logic        irq_o;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] exp_q[$];

  caravel_wb_port_if bus ();

  caravel_wb_port dut (
    .clock  (clock),
    .resetb (resetb),
    .wb     (bus.slave),
    .io_out (io_out),
    .io_oeb (io_oeb),
    .irq_o  (irq_o)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  // One access, bounded to 20 cycles; lat is the number of extra cycles
  // beyond the single expected wait.
  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata,
                           output logic got, output int lat);
    got = 1'b0;
    rdata = 32'h0;
    lat = -1;
    @(negedge clock);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.wbs_ack_o) begin
        got = 1'b1;
        rdata = bus.wbs_dat_o;
        lat = i;
        break;
      end
    end
    bus_idle();
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    logic got;
    int lat;
    wb_access(adr, 1'b1, dat, sel, rd, got, lat);
    check_eq("wr_ack", {31'h0, got}, 32'h1);
    check_eq("wr_lat", lat, 0);
  endtask

  // Expected value is queued at issue and retired when the DUT acks.
  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    logic [31:0] e;
    logic got;
    int lat;
    exp_q.push_back(exp);
    wb_access(adr, 1'b0, 32'h0, 4'hF, rd, got, lat);
    e = exp_q.pop_front();
    if (!got) check_eq("rd_timeout", 32'h0, 32'h1);
    else      check_eq("rd_data", rd, e);
  endtask

  localparam logic [31:0] B = 32'h3000_0000;

  initial begin
    logic [31:0] rd;
    logic got;
    int lat;
    logic [3:0] pat;
    logic [31:0] rnd;
    int waited;

    bus_idle();
    resetb = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_oeb", io_oeb, 32'hFFFF_FFFF);
    check_eq("rst_out", io_out, 32'h0);
    check_eq("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    check_eq("rst_dat", bus.wbs_dat_o, 32'h0);
    check_eq("rst_irq", {31'h0, irq_o}, 32'h0);
    resetb = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("idle_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    check_eq("idle_oeb", io_oeb, 32'hFFFF_FFFF);

    // GPIO progress signalling
    wb_write(B + 32'h0C, 32'h0000_0000, 4'hF);
    check_eq("oeb_zero", io_oeb, 32'h0);
    wb_write(B + 32'h08, 32'hAB60_0000, 4'hF);
    check_eq("io_ab60", {16'h0, io_out[31:16]}, 32'hAB60);
    wb_write(B + 32'h08, 32'hAB61_0000, 4'b1100);
    check_eq("io_ab61", {16'h0, io_out[31:16]}, 32'hAB61);
    wb_write(B + 32'h08, 32'hFFFF_FFFF, 4'b0001);
    check_eq("io_lane0", io_out, 32'hAB61_00FF);
    wb_read(B + 32'h08, 32'hAB61_00FF);

    // Random-data GPIO writes with random lanes, checked through readback
    for (int k = 0; k < 4; k++) begin
      logic [31:0] cur;
      logic [31:0] want;
      cur = io_out;
      rnd = $urandom;
      pat = 4'($urandom_range(0, 15));
      want = cur;
      for (int j = 0; j < 4; j++) if (pat[j]) want[8*j +: 8] = rnd[8*j +: 8];
      wb_write(B + 32'h08, rnd, pat);
      wb_read(B + 32'h08, want);
    end
    wb_write(B + 32'h08, 32'hAB61_0000, 4'hF);

    // Read data stays registered across a following write
    wb_read(B + 32'h0C, 32'h0);
    wb_write(B + 32'h08, 32'hAB61_0000, 4'hF);
    wb_read(B + 32'h08, 32'hAB61_0000);
    wb_write(B + 32'h0C, 32'h0000_0000, 4'hF);
    check_eq("dat_hold", bus.wbs_dat_o, 32'hAB61_0000);

    // Counter byte lanes, then wrap
    wb_write(B + 32'h00, 32'h1234_5678, 4'b0011);
    wb_read(B + 32'h00, 32'h0000_5678);
    wb_write(B + 32'h04, 32'hFFFF_FFFF, 4'hF);
    wb_read(B + 32'h04, 32'h0000_0001);
    wb_write(B + 32'h00, 32'hFFFF_FFFE, 4'hF);
    // Write commits at edge 1; edges 2,3,4 count to FFFFFFFF, 0, 1; the
    // read samples at edge 5 the value before that edge's increment.
    repeat (2) @(negedge clock);
    wb_read(B + 32'h00, 32'h0000_0001);
    wb_write(B + 32'h04, 32'h0, 4'hF);
    wb_read(B + 32'h04, 32'h0);

    // Foreign address never acked; reserved offsets read zero
    wb_access(32'h3100_0000, 1'b0, 32'h0, 4'hF, rd, got, lat);
    check_eq("foreign_noack", {31'h0, got}, 32'h0);
    wb_write(B + 32'h18, 32'hDEAD_BEEF, 4'hF);
    wb_read(B + 32'h18, 32'h0);
    wb_read(B + 32'h1C, 32'h0);
`ifndef CARAVEL_WB_PORT_IRQ_EN
    wb_write(B + 32'h10, 32'h5555_AAAA, 4'hF);
    wb_read(B + 32'h10, 32'h0);
    wb_read(B + 32'h14, 32'h0);
`endif

    // Back-to-back: stb held, ack alternates 1,0,1,0
    @(negedge clock);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = B + 32'h08;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_eq("b2b_ack", {31'h0, bus.wbs_ack_o}, (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    bus_idle();
    @(negedge clock);

`ifdef CARAVEL_WB_PORT_IRQ_EN
    wb_write(B + 32'h00, 32'h0, 4'hF);
    wb_write(B + 32'h10, 32'd10, 4'hF);
    wb_read(B + 32'h10, 32'd10);
    wb_write(B + 32'h14, 32'h1, 4'hF);
    check_eq("irq_pre", {31'h0, irq_o}, 32'h0);
    wb_write(B + 32'h04, 32'h1, 4'hF);
    waited = 0;
    while (!irq_o && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    check_eq("irq_set", {31'h0, irq_o}, 32'h1);
    check_eq("irq_not_early", {31'h0, waited >= 9}, 32'h1);
    wb_write(B + 32'h04, 32'h0, 4'hF);
    wb_read(B + 32'h14, 32'h1);
    wb_write(B + 32'h14, 32'h1, 4'hF);
    check_eq("irq_clr", {31'h0, irq_o}, 32'h0);
    wb_read(B + 32'h14, 32'h0);
`endif

    // Reset while a write is pending: never acked, state cleared
    wb_write(B + 32'h04, 32'h1, 4'hF);
    @(negedge clock);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = B + 32'h08;
    bus.wbs_dat_i = 32'h1111_2222;
    resetb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("rst_mid_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    end
    check_eq("rst_mid_oeb", io_oeb, 32'hFFFF_FFFF);
    check_eq("rst_mid_out", io_out, 32'h0);
    check_eq("rst_mid_dat", bus.wbs_dat_o, 32'h0);
    bus_idle();
    @(negedge clock);
    resetb = 1'b1;
    @(negedge clock);
    wb_read(B + 32'h04, 32'h0);
    wb_read(B + 32'h00, 32'h0);
    wb_read(B + 32'h08, 32'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/caravel_wb_port.md
Name: caravel_wb_port

Overview:
Wishbone-classic 32-bit slave for the Caravel user-project area, reached from the management SoC firmware over the user WB port. It provides a free-running 32-bit counter and GPIO output/enable registers that drive mprj_io. Firmware signals test progress through io_out[31:16]: 0xAB60 means started and 0xAB61 means passed. Sits inside the user project wrapper between the WB bus and the IO pads.

Parameters:
BASE_ADDR, 32'h3000_0000, slave base address; only bits [31:16] are compared.
RESET_OEB, 32'hFFFF_FFFF, reset value of io_oeb; all outputs are disabled at reset.

Ports:
clock  in  1  system clock; every flop is on its rising edge
resetb  in  1  asynchronous active-low reset
wbs_cyc_i  in  1  WB cycle
wbs_stb_i  in  1  WB strobe
wbs_we_i  in  1  WB write enable
wbs_sel_i  in  4  WB byte selects
wbs_adr_i  in  32  WB byte address
wbs_dat_i  in  32  WB write data
wbs_ack_o  out  1  WB acknowledge
wbs_dat_o  out  32  WB read data
io_out  out  32  GPIO output data (mprj_io[31:0])
io_oeb  out  32  GPIO output enable, active-low
irq_o  out  1  interrupt; tied 0 unless the optional feature is compiled in

Behaviour:
- Reset values while resetb=0:
  - COUNT=0, CTRL=0, IO_DATA=0, io_oeb=RESET_OEB.
  - wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
- Select: sel = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16]==BASE_ADDR[31:16]).
  - Addresses outside the base are never acked; another slave responds.
- Handshake:
  - wbs_ack_o rises one cycle after sel when ack is currently 0, and is a single-cycle pulse.
  - Each access therefore takes 2 cycles. Back-to-back accesses re-ack on alternating cycles.
  - Write commit and read-data capture happen on the same edge that sets ack.
  - wbs_dat_o is registered and held until the next read.
  - Dropping cyc or stb before ack aborts the access: no ack, no write.
- Register map (offset = wbs_adr_i[4:2]):
  - 0x00 COUNT, R/W: 32-bit counter.
  - 0x04 CTRL, R/W: bit0 EN. Bits [31:1] read 0.
  - 0x08 IO_DATA, R/W: drives io_out directly.
  - 0x0C IO_OEB, R/W: drives io_oeb directly.
  - 0x10 and 0x14: optional-feature registers, otherwise read 0 and ignore writes.
  - 0x18 and 0x1C: read 0, writes ignored, still acked.
- Byte enables: on a write, only lanes with wbs_sel_i[n]=1 are updated. Reads always return all 32 bits.
- Counter:
  - When EN=1, COUNT increments by 1 every clock.
  - Wraps from 0xFFFF_FFFF to 0x0000_0000.
  - In a cycle where a COUNT write commits, the increment is suppressed: selected bytes take the write data, unselected bytes hold their old value.
  - A read returns the value before that edge's increment.
- Reset mid-transaction: all state clears immediately and asynchronously; the pending access is never acked.

Optional Feature:
Macro CARAVEL_WB_PORT_IRQ_EN.
- Defined:
  - 0x10 COMPARE (R/W, reset 0).
  - 0x14 STATUS: bit0 MATCH, sticky, write-1-to-clear.
  - MATCH sets when EN=1 and COUNT==COMPARE at a clock edge; irq_o = MATCH.
  - A set and a clear in the same cycle resolve to set.
- Undefined: no COMPARE/STATUS flops, 0x10 and 0x14 read 0, irq_o=0.

Decomposition:
- Package caravel_wb_port_pkg holds:
  - register offset localparams: ADDR_COUNT=3'd0, ADDR_CTRL=3'd1, ADDR_IO_DATA=3'd2, ADDR_IO_OEB=3'd3, ADDR_COMPARE=3'd4, ADDR_STATUS=3'd5
  - CTRL_EN_BIT=0
  - the default constants for BASE_ADDR and RESET_OEB.
- One sub-module, wb_byte_reg: a 32-bit register with 4 byte-lane write enables and a reset value. It is used for COUNT, IO_DATA, IO_OEB and COMPARE.

Test Plan:
- Reset, then no access -> io_oeb=0xFFFF_FFFF, io_out=0, wbs_ack_o=0, irq_o=0.
- Write IO_OEB=0x0000_0000, then IO_DATA=0xAB60_0000 -> io_out[31:16]=0xAB60, and ack is a single-cycle pulse 1 cycle after stb. Then write 0xAB61_0000 -> io_out[31:16]=0xAB61.
- Write COUNT=0x1234_5678 with sel=4'b0011 starting from COUNT=0 -> read returns 0x0000_5678. Write sel=4'b1111 value 0xFFFF_FFFE with EN=1, then wait 2 cycles -> COUNT has wrapped through 0 (read value 0x0000_0000 or later, consistent with cycle count).
- Access address 0x3100_0000 -> no ack for 20 cycles. Read offset 0x1C -> acked, data 0.
- Assert resetb=0 while stb is pending -> no ack, and all registers back to reset values.
- With CARAVEL_WB_PORT_IRQ_EN: COMPARE=10, COUNT=0, EN=1 -> irq_o=1 after 10 increments. Write 1 to STATUS -> irq_o=0 on the next cycle.
